delay_issue_scheduler: RTL and testbench

- Shares one fixed-latency delay/processing resource between N_REQ requesters.
- Round-robin arbitration picks one requester per cycle. The winner is issued to the resource as a one-cycle enable pulse tagged with its ID.
- An in-flight tracker knows when each issued operation must complete. It routes the completion back to the originating requester as a done pulse and checks the resource's own completion strobe against that expectation.
- Sits between the control-path requesters and the delay unit, which is driven by `issue` and returns `res_done`.

---
 rtl/delay_issue_scheduler.sv | 146 ++++++++++++++
 tb/tb_delay_issue_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/delay_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : delay_issue_scheduler
// Brief    : Round-robin issue scheduler for a shared fixed-latency resource.
//            Grants one requester per cycle within a credit limit, tracks
//            in-flight operations, routes completions back as done pulses
//            and flags protocol errors on missing or spurious completions.
// Revision : 1.0 - initial release
// ============================================================================
module delay_issue_scheduler #(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int LAT     = 8,
  parameter int MAX_OUT = 4,
  parameter int CNTW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             issue,
  output logic [IDW-1:0]   issue_id,
  input  logic             res_done,
  output logic [N_REQ-1:0] done,
  output logic [CNTW-1:0]  outstanding,
  output logic             busy,
  output logic             err
);

  // Registered outputs and arbitration pointer
  logic [N_REQ-1:0] r_gnt;
  logic             r_issue;
  logic [IDW-1:0]   r_issue_id;
  logic [N_REQ-1:0] r_done;
  logic [CNTW-1:0]  r_out;
  logic             r_busy;
  logic             r_err;
  logic [IDW-1:0]   r_ptr;

  // Tracker: stage 0 holds the op issued last cycle, stage LAT-1 is expiry
  logic [LAT-1:0]   r_tv;
  logic [IDW-1:0]   r_tid [LAT];

  // Combinational arbitration / credit signals
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW:0]     w_idx;
  logic             w_exp_v;
  logic [IDW-1:0]   w_exp_id;
  logic [CNTW:0]    w_cnt_next;
  logic             w_credit;
  logic             w_grant;
  logic [IDW-1:0]   w_ptr_next;

  assign w_exp_v  = r_tv[LAT-1];
  assign w_exp_id = r_tid[LAT-1];

  // In-flight count after this edge; the op currently on issue is counted
  // so that a credit is never handed out twice.
  assign w_cnt_next = {1'b0, r_out} + (CNTW+1)'(r_issue) - (CNTW+1)'(w_exp_v);
  assign w_credit   = (w_cnt_next < (CNTW+1)'(MAX_OUT));
  assign w_grant    = w_found && w_credit;

  // Round-robin search starting at the pointer, wrapping modulo N_REQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(N_REQ)) begin
        w_idx = w_idx - (IDW+1)'(N_REQ);
      end
      if (!w_found && req[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  // Pointer advances to the requester after the winner, wrapping
  always_comb begin
    w_ptr_next = w_win + IDW'(1);
    if (w_win == IDW'(N_REQ - 1)) begin
      w_ptr_next = '0;
    end
  end

  // Issue, grant and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt      <= '0;
      r_issue    <= 1'b0;
      r_issue_id <= '0;
      r_ptr      <= '0;
    end else begin
      r_gnt      <= w_grant ? (N_REQ'(1) << w_win) : '0;
      r_issue    <= w_grant;
      r_issue_id <= w_grant ? w_win : '0;
      if (w_grant) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  // In-flight tracker shift register, loaded from the registered issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tv <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_tid[i] <= '0;
      end
    end else begin
      r_tv     <= {r_tv[LAT-2:0], r_issue};
      r_tid[0] <= r_issue_id;
      for (int i = 1; i < LAT; i++) begin
        r_tid[i] <= r_tid[i-1];
      end
    end
  end

  // Completion routing, sticky error, in-flight count and busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= '0;
      r_err  <= 1'b0;
      r_out  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_done <= w_exp_v ? (N_REQ'(1) << w_exp_id) : '0;
      r_err  <= r_err | (w_exp_v ^ res_done);
      r_out  <= w_cnt_next[CNTW-1:0];
      r_busy <= (w_cnt_next != '0);
    end
  end

  assign gnt         = r_gnt;
  assign issue       = r_issue;
  assign issue_id    = r_issue_id;
  assign done        = r_done;
  assign outstanding = r_out;
  assign busy        = r_busy;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_delay_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_issue_scheduler
// Brief    : Directed self-checking bench for delay_issue_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_issue_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       issue;
  logic [1:0] issue_id;
  logic       res_done;
  logic [3:0] done;
  logic [3:0] outstanding;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  delay_issue_scheduler #(
    .N_REQ(4), .IDW(2), .LAT(8), .MAX_OUT(4), .CNTW(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .issue(issue),
    .issue_id(issue_id), .res_done(res_done), .done(done),
    .outstanding(outstanding), .busy(busy), .err(err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Apply reset for two edges; returns at the start of cycle 0
  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    res_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; res_done = 1'b0;
    #3;
    n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_checks++; if (issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue got=%b exp=0", issue); end
    n_checks++; if (issue_id !== 2'd0) begin n_fail++; $display("FAIL reset_issue_id got=%0d exp=0", issue_id); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0000", done); end
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    step();
    req = '0;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt cyc=%0d got=%b exp=0100", cyc, gnt); end
    n_checks++; if (issue !== 1'b1) begin n_fail++; $display("FAIL single_issue cyc=%0d got=%b exp=1", cyc, issue); end
    n_checks++; if (issue_id !== 2'd2) begin n_fail++; $display("FAIL single_issue_id cyc=%0d got=%0d exp=2", cyc, issue_id); end
    for (int c = 2; c <= 9; c++) begin
      step();
      n_checks++; if (outstanding !== 4'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_inflight cyc=%0d got=%0d/%b exp=1/1", cyc, outstanding, busy); end
      n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL single_early_done cyc=%0d got=%b exp=0000", cyc, done); end
      if (c == 9) res_done = 1'b1;
    end
    step();
    res_done = 1'b0;
    n_checks++; if (done !== 4'b0100) begin n_fail++; $display("FAIL single_done cyc=%0d got=%b exp=0100", cyc, done); end
    n_checks++; if (outstanding !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_drain cyc=%0d got=%0d/%b exp=0/0", cyc, outstanding, busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err cyc=%0d got=%b exp=0", cyc, err); end
    step();
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL single_done_pulse cyc=%0d got=%b exp=0000", cyc, done); end
  endtask

  task automatic test_rr_credits();
    logic [3:0] eg;
    logic [3:0] ed;
    int         eid;
    do_reset();
    req = 4'hF;
    for (int c = 1; c <= 13; c++) begin
      step();
      res_done = (c >= 9 && c <= 12);
      eid = -1;
      if (c <= 4) eid = c - 1;
      else if (c >= 10) eid = c - 10;
      eg = (eid >= 0) ? 4'(1 << eid) : 4'b0;
      ed = (c >= 10) ? 4'(1 << (c - 10)) : 4'b0;
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg); end
      n_checks++; if (issue !== (eid >= 0)) begin n_fail++; $display("FAIL rr_issue cyc=%0d got=%b exp=%b", cyc, issue, (eid >= 0)); end
      if (eid >= 0) begin
        n_checks++; if (issue_id !== 2'(eid)) begin n_fail++; $display("FAIL rr_issue_id cyc=%0d got=%0d exp=%0d", cyc, issue_id, eid); end
      end
      n_checks++; if (done !== ed) begin n_fail++; $display("FAIL rr_done cyc=%0d got=%b exp=%b", cyc, done, ed); end
      if (c == 5) begin
        n_checks++; if (outstanding !== 4'd4) begin n_fail++; $display("FAIL rr_full cyc=%0d got=%0d exp=4", cyc, outstanding); end
      end
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err got=%b exp=0", err); end
  endtask

  task automatic test_fairness();
    int eid;
    do_reset();
    req = 4'b1010;
    for (int c = 1; c <= 4; c++) begin
      step();
      eid = (c % 2 == 1) ? 1 : 3;
      n_checks++; if (gnt !== 4'(1 << eid)) begin n_fail++; $display("FAIL fair_gnt cyc=%0d got=%b exp=%0d", cyc, gnt, eid); end
      n_checks++; if (issue_id !== 2'(eid)) begin n_fail++; $display("FAIL fair_issue_id cyc=%0d got=%0d exp=%0d", cyc, issue_id, eid); end
    end
    req = '0;
  endtask

  task automatic test_missing();
    do_reset();
    req = 4'b0001;
    step();
    req = '0;
    n_checks++; if (issue !== 1'b1) begin n_fail++; $display("FAIL miss_issue cyc=%0d got=%b exp=1", cyc, issue); end
    for (int c = 2; c <= 9; c++) step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL miss_err_early cyc=%0d got=%b exp=0", cyc, err); end
    step();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL miss_err cyc=%0d got=%b exp=1", cyc, err); end
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL miss_done cyc=%0d got=%b exp=0001", cyc, done); end
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL miss_outstanding cyc=%0d got=%0d exp=0", cyc, outstanding); end
    for (int c = 11; c <= 13; c++) begin
      step();
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL miss_err_sticky cyc=%0d got=%b exp=1", cyc, err); end
      n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL miss_done_extra cyc=%0d got=%b exp=0000", cyc, done); end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      step();
      n_checks++; if (err !== (c >= 6)) begin n_fail++; $display("FAIL spur_err cyc=%0d got=%b exp=%b", cyc, err, (c >= 6)); end
      n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL spur_done cyc=%0d got=%b exp=0000", cyc, done); end
      res_done = (c == 5);
    end
    res_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0111;
    step(); step(); step();
    req = '0;
    n_checks++; if (issue_id !== 2'd2) begin n_fail++; $display("FAIL mid_third_issue cyc=%0d got=%0d exp=2", cyc, issue_id); end
    step(); step();
    n_checks++; if (outstanding !== 4'd3) begin n_fail++; $display("FAIL mid_inflight cyc=%0d got=%0d exp=3", cyc, outstanding); end
    reset = 1'b1;
    #1;
    n_checks++; if ({gnt, issue, issue_id, done, outstanding, busy, err} !== 16'b0) begin
      n_fail++; $display("FAIL mid_async_clear got=%h exp=0", {gnt, issue, issue_id, done, outstanding, busy, err});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    req   = 4'b1001;
    step();
    req = '0;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_reset cyc=%0d got=%b exp=0001", cyc, gnt); end
    for (int c = 2; c <= 12; c++) begin
      step();
      res_done = (c == 9);
      n_checks++; if (done !== ((c == 10) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL mid_done cyc=%0d got=%b exp=%b", cyc, done, (c == 10) ? 4'b0001 : 4'b0000); end
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%b exp=0", err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_credits();
    test_fairness();
    test_missing();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
